// File: rtl/snn_mac_sequencer_if.sv
// Control bundle between the SNN MAC sequencer and the datapath it steers.
// master = sequencer (drives addresses/strobes), slave = datapath side.
interface snn_mac_sequencer_if #(
   parameter int unsigned NUM_IN  = 784,
   parameter int unsigned NUM_HID = 32,
   parameter int unsigned NUM_OUT = 10
);
   localparam int unsigned AwIn  = $clog2(NUM_IN);
   localparam int unsigned AwHid = $clog2(NUM_HID);
   localparam int unsigned AwOut = $clog2(NUM_OUT);
   localparam int unsigned AwHw  = $clog2(NUM_IN * NUM_HID);
   localparam int unsigned AwOw  = $clog2(NUM_HID * NUM_OUT);

   logic             start;
   logic [7:0]       act_q;
   logic [AwIn-1:0]  addr_input_unit;
   logic [AwHw-1:0]  addr_hw;
   logic [AwOw-1:0]  addr_ow;
   logic [AwHid-1:0] addr_hidden;
   logic [AwOut-1:0] addr_output;
   logic             sel_layer;
   logic             mac_clr;
   logic             mac_en;
   logic             lut_rd;
   logic             we_hidden;
   logic             we_output;
   logic [AwOut-1:0] digit;
   logic             done;

   modport master (
      input  start, act_q,
      output addr_input_unit, addr_hw, addr_ow, addr_hidden, addr_output, sel_layer,
             mac_clr, mac_en, lut_rd, we_hidden, we_output, digit, done
   );

   modport slave (
      output start, act_q,
      input  addr_input_unit, addr_hw, addr_ow, addr_hidden, addr_output, sel_layer,
             mac_clr, mac_en, lut_rd, we_hidden, we_output, digit, done
   );
endinterface

// File: rtl/snn_mac_sequencer.sv
// Sequencer for the SNN core: hidden layer then output layer on one shared MAC,
// with a running argmax over the output activations.
module snn_mac_sequencer #(
   parameter int unsigned NUM_IN  = 784,
   parameter int unsigned NUM_HID = 32,
   parameter int unsigned NUM_OUT = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   snn_mac_sequencer_if.master bus
);
   localparam int unsigned AwIn  = $clog2(NUM_IN);
   localparam int unsigned AwHid = $clog2(NUM_HID);
   localparam int unsigned AwOut = $clog2(NUM_OUT);
   localparam int unsigned AwHw  = $clog2(NUM_IN * NUM_HID);
   localparam int unsigned AwOw  = $clog2(NUM_HID * NUM_OUT);

   localparam logic [AwIn-1:0]  KLast = AwIn'(NUM_IN - 1);
   localparam logic [AwHid-1:0] JLast = AwHid'(NUM_HID - 1);
   localparam logic [AwHid-1:0] HLast = AwHid'(NUM_HID - 1);
   localparam logic [AwOut-1:0] OLast = AwOut'(NUM_OUT - 1);

   typedef enum logic [3:0] {
      StIdle, StHidMac, StHidBp1, StHidBp2, StHidWr,
      StOutMac, StOutBp1, StOutBp2, StOutWr, StDone
   } state_e;

   state_e           state_q, state_d;
   logic [AwIn-1:0]  k_q;
   logic [AwHid-1:0] j_q, h_q;
   logic [AwOut-1:0] o_q, digit_q;
   logic [AwHw-1:0]  hw_q;
   logic [AwOw-1:0]  ow_q;
   logic [7:0]       best_q;
   logic             mac_en_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.start) state_d = StHidMac;
         StHidMac: if (k_q == KLast) state_d = StHidBp1;
         StHidBp1: state_d = StHidBp2;
         StHidBp2: state_d = StHidWr;
         StHidWr:  state_d = (h_q == HLast) ? StOutMac : StHidMac;
         StOutMac: if (j_q == JLast) state_d = StOutBp1;
         StOutBp1: state_d = StOutBp2;
         StOutBp2: state_d = StOutWr;
         StOutWr:  state_d = (o_q == OLast) ? StDone : StOutMac;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Weight addresses run continuously across units so no h*NUM_IN product is needed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k_q      <= '0;
         j_q      <= '0;
         h_q      <= '0;
         o_q      <= '0;
         hw_q     <= '0;
         ow_q     <= '0;
         best_q   <= '0;
         digit_q  <= '0;
         mac_en_q <= 1'b0;
      end else begin
         mac_en_q <= (state_q == StHidMac) || (state_q == StOutMac);
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  k_q    <= '0;
                  j_q    <= '0;
                  h_q    <= '0;
                  o_q    <= '0;
                  hw_q   <= '0;
                  ow_q   <= '0;
                  best_q <= '0;
               end
            end
            StHidMac: begin
               hw_q <= hw_q + 1'b1;
               if (k_q != KLast) k_q <= k_q + 1'b1;
            end
            StHidWr: begin
               k_q <= '0;
               h_q <= h_q + 1'b1;
            end
            StOutMac: begin
               ow_q <= ow_q + 1'b1;
               if (j_q != JLast) j_q <= j_q + 1'b1;
            end
            StOutWr: begin
               j_q <= '0;
               o_q <= o_q + 1'b1;
               // Strict compare: ties keep the lower index.
               if (bus.act_q > best_q || o_q == '0) begin
                  best_q  <= bus.act_q;
                  digit_q <= o_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.addr_input_unit = k_q;
   assign bus.addr_hw         = hw_q;
   assign bus.addr_ow         = ow_q;
   assign bus.addr_output     = o_q;
   assign bus.mac_en          = mac_en_q;
   assign bus.digit           = digit_q;

   always_comb begin
      bus.mac_clr     = 1'b0;
      bus.lut_rd      = 1'b0;
      bus.we_hidden   = 1'b0;
      bus.we_output   = 1'b0;
      bus.done        = 1'b0;
      bus.sel_layer   = 1'b0;
      bus.addr_hidden = h_q;
      unique case (state_q)
         StIdle:   bus.mac_clr = 1'b1;
         StHidBp2: bus.lut_rd = 1'b1;
         StHidWr: begin
            bus.we_hidden = 1'b1;
            bus.mac_clr   = 1'b1;
         end
         StOutMac: begin
            bus.sel_layer   = 1'b1;
            bus.addr_hidden = j_q;
         end
         StOutBp1: bus.sel_layer = 1'b1;
         StOutBp2: begin
            bus.sel_layer = 1'b1;
            bus.lut_rd    = 1'b1;
         end
         StOutWr: begin
            bus.sel_layer = 1'b1;
            bus.we_output = 1'b1;
            bus.mac_clr   = 1'b1;
         end
         StDone:   bus.done = 1'b1;
         default: ;
      endcase
   end
endmodule
